// File: rtl/ssm2603_i2s_tx_if.sv
// Stereo sample-pair valid/ready stream feeding the SSM2603 I2S playback serializer.
// The master (upstream) drives the pair and valid; the slave (serializer) drives ready.
interface ssm2603_i2s_tx_if #(
  parameter int WL = 16
);
  logic          s_valid;
  logic          s_ready;
  logic [WL-1:0] s_left;
  logic [WL-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/ssm2603_i2s_tx.sv
// I2S bus-master playback serializer for the SSM2603 (BCLK, PBLRC, PBDAT from one stereo holding register).
// Optional SSM2603_TX_REPEAT_EN: on underrun re-send the last transmitted pair instead of zeros.
module ssm2603_i2s_tx #(
  parameter int WL       = 16,
  parameter int BCLK_DIV = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_done,
  ssm2603_i2s_tx_if.slave      s,
  output logic                 AC_BCLK,
  output logic                 AC_PBLRC,
  output logic                 AC_PBDAT,
  output logic                 underrun
);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);

  logic [DW-1:0] div_cnt_reg;
  logic [5:0]    bit_cnt_reg;
  logic          hold_full_reg;
  logic          started_reg;
  logic [WL-1:0] hold_l_reg, hold_r_reg;
  logic [WL-1:0] shift_l_reg, shift_r_reg;
  logic          bclk_reg, lrc_reg, dat_reg, underrun_reg;
`ifdef SSM2603_TX_REPEAT_EN
  logic [WL-1:0] last_l_reg, last_r_reg;
`endif

  logic          en, wrap, boundary, in_slot, hs;
  logic [DW-1:0] div_next;
  logic [5:0]    bit_next;
  logic [4:0]    slot_b;
  logic [WL-1:0] load_l, load_r;

  always_comb begin
    en       = cfg_done & ~reset;
    wrap     = (div_cnt_reg == DIV_LAST);
    div_next = wrap ? '0 : div_cnt_reg + 1'b1;
    bit_next = bit_cnt_reg + 6'd1;
    boundary = wrap & (bit_cnt_reg == 6'd63);
    slot_b   = bit_next[4:0];
    // Slot 0 is the I2S one-bit delay; sample bits occupy slots 1..WL.
    in_slot  = (slot_b != 5'd0) && ({1'b0, slot_b} <= 6'(WL));
    hs       = s.s_valid & s.s_ready;
`ifdef SSM2603_TX_REPEAT_EN
    load_l   = hold_full_reg ? hold_l_reg : last_l_reg;
    load_r   = hold_full_reg ? hold_r_reg : last_r_reg;
`else
    load_l   = hold_full_reg ? hold_l_reg : '0;
    load_r   = hold_full_reg ? hold_r_reg : '0;
`endif
  end

  assign s.s_ready = en & ~hold_full_reg;
  assign AC_BCLK   = bclk_reg;
  assign AC_PBLRC  = lrc_reg;
  assign AC_PBDAT  = dat_reg;
  assign underrun  = underrun_reg;

  always_ff @(posedge clk) begin
    if (!en) begin
      // Idle counters sit one step before a frame boundary so the first enabled edge starts a frame.
      div_cnt_reg   <= DIV_LAST;
      bit_cnt_reg   <= 6'd63;
      hold_full_reg <= 1'b0;
      started_reg   <= 1'b0;
      hold_l_reg    <= '0;
      hold_r_reg    <= '0;
      shift_l_reg   <= '0;
      shift_r_reg   <= '0;
      bclk_reg      <= 1'b0;
      lrc_reg       <= 1'b0;
      dat_reg       <= 1'b0;
      underrun_reg  <= 1'b0;
`ifdef SSM2603_TX_REPEAT_EN
      last_l_reg    <= '0;
      last_r_reg    <= '0;
`endif
    end else begin
      div_cnt_reg  <= div_next;
      bclk_reg     <= (div_next >= DIV_HALF);
      underrun_reg <= boundary & ~hold_full_reg & started_reg;
      if (wrap) begin
        bit_cnt_reg <= bit_next;
        lrc_reg     <= bit_next[5];
        if (boundary) begin
          shift_l_reg   <= load_l;
          shift_r_reg   <= load_r;
          dat_reg       <= 1'b0;
          hold_full_reg <= 1'b0;
`ifdef SSM2603_TX_REPEAT_EN
          last_l_reg    <= load_l;
          last_r_reg    <= load_r;
`endif
        end else if (in_slot) begin
          if (bit_next[5]) begin
            dat_reg     <= shift_r_reg[WL-1];
            shift_r_reg <= {shift_r_reg[WL-2:0], 1'b0};
          end else begin
            dat_reg     <= shift_l_reg[WL-1];
            shift_l_reg <= {shift_l_reg[WL-2:0], 1'b0};
          end
        end else begin
          dat_reg <= 1'b0;
        end
      end
      // ready is low while full, so this never overlaps a boundary clear of a full register.
      if (hs) begin
        hold_l_reg    <= s.s_left;
        hold_r_reg    <= s.s_right;
        hold_full_reg <= 1'b1;
        started_reg   <= 1'b1;
      end
    end
  end
endmodule
